// File: rtl/wb_bus_if_pkg.sv
// wb_bus_if_pkg: shared state encoding, bus widths and defaults for the Wishbone bridge
package wb_bus_if_pkg;
    localparam int BUS_W = 32;
    localparam int SEL_W = 4;
    localparam int TIMEOUT_DEF = 16;
    localparam logic [BUS_W-1:0] ZERO_WORD = '0;
    typedef enum logic [1:0] {
        IDLE           = 2'd0,
        BUSY           = 2'd1,
        WAIT_FOR_STALL = 2'd2
    } state_e;
endpackage

// File: rtl/wb_bus_if.sv
// wb_bus_if: core memory port to Wishbone B4 classic master bridge with stall request,
// read-data hold while the pipeline stays stalled, and an ack timeout.
module wb_bus_if
    import wb_bus_if_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       stall_i,
    input  logic             flush_i,
    input  logic             cpu_ce_i,
    input  logic             cpu_we_i,
    input  logic [SEL_W-1:0] cpu_sel_i,
    input  logic [BUS_W-1:0] cpu_addr_i,
    input  logic [BUS_W-1:0] cpu_data_i,
    output logic [BUS_W-1:0] cpu_data_o,
    output logic             stallreq,
    output logic             bus_err_o,
    input  logic [BUS_W-1:0] wishbone_data_i,
    input  logic             wishbone_ack_i,
    output logic [BUS_W-1:0] wishbone_addr_o,
    output logic [BUS_W-1:0] wishbone_data_o,
    output logic             wishbone_we_o,
    output logic [SEL_W-1:0] wishbone_sel_o,
    output logic             wishbone_stb_o,
    output logic             wishbone_cyc_o
);
    localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

    state_e state, next;
    logic [7:0] cnt;
    logic [BUS_W-1:0] rd_buf;
    logic busy, start, timeout_hit, ack, clr;

    assign busy        = state == BUSY;
    assign start       = state == IDLE && cpu_ce_i && !flush_i;
    assign timeout_hit = busy && cnt == LAST;
    assign ack         = busy && wishbone_ack_i;
    assign clr         = busy && (flush_i || wishbone_ack_i || timeout_hit);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= next;
    end

    always_comb begin
        next       = state;
        stallreq   = 1'b0;
        cpu_data_o = ZERO_WORD;
        case (state)
            IDLE: begin
                stallreq = cpu_ce_i & ~flush_i;
                next     = stallreq ? BUSY : IDLE;
            end
            BUSY: begin
                stallreq   = ~wishbone_ack_i & ~flush_i & ~timeout_hit;
                cpu_data_o = (wishbone_ack_i && !wishbone_we_o && !flush_i) ? wishbone_data_i : ZERO_WORD;
                next       = flush_i ? IDLE :
                             wishbone_ack_i ? (|stall_i ? WAIT_FOR_STALL : IDLE) :
                             timeout_hit ? WAIT_FOR_STALL : BUSY;
            end
            WAIT_FOR_STALL: begin
                cpu_data_o = rd_buf;
                next       = (~|stall_i || flush_i) ? IDLE : WAIT_FOR_STALL;
            end
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wishbone_addr_o <= ZERO_WORD;
            wishbone_data_o <= ZERO_WORD;
            wishbone_we_o   <= 1'b0;
            wishbone_sel_o  <= '0;
            wishbone_stb_o  <= 1'b0;
            wishbone_cyc_o  <= 1'b0;
            rd_buf          <= ZERO_WORD;
            cnt             <= '0;
            bus_err_o       <= 1'b0;
        end else begin
            bus_err_o <= timeout_hit && !flush_i && !wishbone_ack_i;
            cnt       <= start ? 8'd0 : busy ? cnt + 8'd1 : cnt;
            if (start) begin
                wishbone_addr_o <= cpu_addr_i;
                wishbone_data_o <= cpu_data_i;
                wishbone_we_o   <= cpu_we_i;
                wishbone_sel_o  <= cpu_sel_i;
                wishbone_stb_o  <= 1'b1;
                wishbone_cyc_o  <= 1'b1;
            end else if (clr) begin
                wishbone_addr_o <= ZERO_WORD;
                wishbone_data_o <= ZERO_WORD;
                wishbone_we_o   <= 1'b0;
                wishbone_sel_o  <= '0;
                wishbone_stb_o  <= 1'b0;
                wishbone_cyc_o  <= 1'b0;
            end
            // Flush and timeout both leave nothing valid to hand back to the core
            if (busy && flush_i) rd_buf <= ZERO_WORD;
            else if (ack && !wishbone_we_o) rd_buf <= wishbone_data_i;
            else if (timeout_hit) rd_buf <= ZERO_WORD;
        end
    end
endmodule
